// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - pipeline stage register with valid/ready handshake and 2-entry skid
// Head drives the outputs directly; skid holds the second-oldest word; in_ready is registered.
module pipe_stage_buffer #(
  parameter int                 CTRL_W         = 16,
  parameter int                 DATA_W         = 128,
  parameter logic [CTRL_W-1:0]  CTRL_KILL_MASK = {CTRL_W{1'b1}},
  parameter logic [31:0]        RESET_PC       = 32'h80000004
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic              in_flushed,
  input  logic              flush,
  input  logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic              out_flushed,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
    logic              flushed;
  } word_t;

  word_t      head, skid, head_n, skid_n, in_word;
  logic [1:0] occ, occ_n;
  logic       push, pop;

  function automatic word_t kill(input word_t w);
    word_t k;
    k         = w;
    k.ctrl    = w.ctrl & ~CTRL_KILL_MASK;
    k.flushed = 1'b1;
    return k;
  endfunction

  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready & ~stall;
  assign in_word = '{ctrl: in_ctrl, data: in_data, pc: in_pc, flushed: in_flushed};

  always_comb begin
    head_n = head;
    skid_n = skid;
    occ_n  = occ;
    case (occ)
      2'd0: begin
        if (push) begin
          head_n = in_word;
          occ_n  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_n = in_word;
        end else if (push) begin
          skid_n = in_word;
          occ_n  = 2'd2;
        end else if (pop) begin
          occ_n  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_n = skid;
          occ_n  = 2'd1;
        end
      end
      default: occ_n = 2'd0;
    endcase
    // A word popped this cycle has already been sampled, so only survivors are killed.
    if (flush) begin
      if (occ_n != 2'd0) head_n = kill(head_n);
      if (occ_n == 2'd2) skid_n = kill(skid_n);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '{ctrl: '0, data: '0, pc: RESET_PC, flushed: 1'b0};
      skid     <= '0;
      occ      <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      head     <= head_n;
      skid     <= skid_n;
      occ      <= occ_n;
      in_ready <= (occ_n != 2'd2);
    end
  end

  assign out_valid   = (occ != 2'd0);
  assign out_ctrl    = head.ctrl;
  assign out_data    = head.data;
  assign out_pc      = head.pc;
  assign out_flushed = head.flushed;
  assign occupancy   = occ;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb/tb_pipe_stage_buffer.sv - self-checking bench for pipe_stage_buffer
// A queue-based model tracks held words; outputs are compared on every falling edge.
module tb_pipe_stage_buffer;

  localparam logic [15:0] MASK = 16'h00F0;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_ctrl = '0;
  logic [127:0] in_data = '0;
  logic [31:0]  in_pc = '0;
  logic         in_flushed = 1'b0;
  logic         flush = 1'b0;
  logic         stall = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  out_ctrl;
  logic [127:0] out_data;
  logic [31:0]  out_pc;
  logic         out_flushed;
  logic [1:0]   occupancy;

  int pass_cnt = 0;
  int total_cnt = 0;

  pipe_stage_buffer #(
    .CTRL_W(16), .DATA_W(128), .CTRL_KILL_MASK(MASK), .RESET_PC(32'h80000004)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc), .in_flushed(in_flushed),
    .flush(flush), .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_pc(out_pc),
    .out_flushed(out_flushed), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  ctrl;
    logic [127:0] data;
    logic [31:0]  pc;
    logic         flushed;
  } mword_t;

  mword_t mq[$];
  logic   m_ready = 1'b1;

  always @(posedge clk or negedge reset) begin
    mword_t w;
    if (!reset) begin
      mq.delete();
      m_ready = 1'b1;
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && m_ready;
      do_pop  = (mq.size() > 0) && out_ready && !stall;
      if (do_pop) w = mq.pop_front();
      if (do_push) begin
        w.ctrl = in_ctrl; w.data = in_data; w.pc = in_pc; w.flushed = in_flushed;
        mq.push_back(w);
      end
      if (flush) begin
        foreach (mq[i]) begin
          mq[i].ctrl    = mq[i].ctrl & ~MASK;
          mq[i].flushed = 1'b1;
        end
      end
      m_ready = (mq.size() < 2);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_model();
    check("occupancy", {126'd0, occupancy}, 128'(mq.size()));
    check("in_ready", {127'd0, in_ready}, {127'd0, m_ready});
    check("out_valid", {127'd0, out_valid}, {127'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("out_ctrl", {112'd0, out_ctrl}, {112'd0, mq[0].ctrl});
      check("out_data", out_data, mq[0].data);
      check("out_pc", {96'd0, out_pc}, {96'd0, mq[0].pc});
      check("out_flushed", {127'd0, out_flushed}, {127'd0, mq[0].flushed});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [127:0] d,
                       input logic [31:0] p, input logic f);
    in_valid = v; in_ctrl = c; in_data = d; in_pc = p; in_flushed = f;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_out_pc", {96'd0, out_pc}, {96'd0, 32'h80000004});
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_occ", {126'd0, occupancy}, 128'd0);

    // 1: async reset with two words held
    out_ready = 1'b0;
    drive(1, 16'hAAAA, 128'h200, 32'h200, 0); cycle();
    drive(1, 16'hBBBB, 128'h204, 32'h204, 0); cycle();
    drive(0, 16'h0, 128'h0, 32'h0, 0);
    check("t1_occ_full", {126'd0, occupancy}, 128'd2);
    reset = 1'b0;
    #1;
    compare_model();
    check("t1_valid", {127'd0, out_valid}, 128'd0);
    check("t1_pc", {96'd0, out_pc}, {96'd0, 32'h80000004});
    check("t1_occ", {126'd0, occupancy}, 128'd0);
    check("t1_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 16'h0011, 128'h100, 32'h100, 0); cycle();
    drive(0, 16'h0, 128'h0, 32'h0, 0);
    check("t1_first_pc", {96'd0, out_pc}, {96'd0, 32'h100});
    check("t1_first_valid", {127'd0, out_valid}, 128'd1);
    out_ready = 1'b1; cycle();

    // 2: streaming at full rate; word 3 arrives already flushed
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'(i + 1), 128'(i * 7), 32'(i * 4), (i == 3));
      cycle();
      check("t2_pc", {96'd0, out_pc}, 128'(i * 4));
      check("t2_ready", {127'd0, in_ready}, 128'd1);
    end
    drive(0, 16'h0, 128'h0, 32'h0, 0); cycle();
    check("t2_drained", {126'd0, occupancy}, 128'd0);

    // 3: backpressure
    out_ready = 1'b0;
    drive(1, 16'h0A0A, 128'hA, 32'h300, 0); cycle();
    drive(1, 16'h0B0B, 128'hB, 32'h304, 0); cycle();
    check("t3_ready_low", {127'd0, in_ready}, 128'd0);
    drive(1, 16'h0C0C, 128'hC, 32'h308, 0); cycle();
    check("t3_occ", {126'd0, occupancy}, 128'd2);
    check("t3_head_a", {96'd0, out_pc}, {96'd0, 32'h300});
    out_ready = 1'b1; cycle();
    check("t3_head_b", {96'd0, out_pc}, {96'd0, 32'h304});
    cycle();
    check("t3_head_c", {96'd0, out_pc}, {96'd0, 32'h308});
    drive(0, 16'h0, 128'h0, 32'h0, 0); cycle();
    check("t3_empty", {126'd0, occupancy}, 128'd0);

    // 4: flush a full stage
    out_ready = 1'b0;
    drive(1, 16'hFFFF, 128'hD1, 32'h400, 0); cycle();
    drive(1, 16'hFFFF, 128'hD2, 32'h404, 0); cycle();
    drive(0, 16'h0, 128'h0, 32'h0, 0);
    flush = 1'b1; cycle(); flush = 1'b0;
    check("t4_ctrl", {112'd0, out_ctrl}, {112'd0, 16'hFF0F});
    check("t4_flushed", {127'd0, out_flushed}, 128'd1);
    check("t4_data", out_data, 128'hD1);
    check("t4_pc", {96'd0, out_pc}, {96'd0, 32'h400});
    check("t4_occ", {126'd0, occupancy}, 128'd2);
    out_ready = 1'b1; cycle();
    check("t4_skid_ctrl", {112'd0, out_ctrl}, {112'd0, 16'hFF0F});
    check("t4_skid_pc", {96'd0, out_pc}, {96'd0, 32'h404});
    cycle();

    // 5: flush + push + pop at occupancy 1
    out_ready = 1'b0;
    drive(1, 16'h1234, 128'hE1, 32'h500, 0); cycle();
    check("t5_pre_ctrl", {112'd0, out_ctrl}, {112'd0, 16'h1234});
    check("t5_pre_flushed", {127'd0, out_flushed}, 128'd0);
    drive(1, 16'hFFFF, 128'hE2, 32'h504, 0);
    flush = 1'b1; out_ready = 1'b1; cycle();
    flush = 1'b0; out_ready = 1'b0;
    drive(0, 16'h0, 128'h0, 32'h0, 0);
    check("t5_pc", {96'd0, out_pc}, {96'd0, 32'h504});
    check("t5_ctrl", {112'd0, out_ctrl}, {112'd0, 16'hFF0F});
    check("t5_flushed", {127'd0, out_flushed}, 128'd1);
    check("t5_occ", {126'd0, occupancy}, 128'd1);
    out_ready = 1'b1; cycle();

    // 6: stall while pushing
    out_ready = 1'b0;
    drive(1, 16'h0600, 128'hF0, 32'h600, 0); cycle();
    out_ready = 1'b1; stall = 1'b1;
    drive(1, 16'h0604, 128'hF4, 32'h604, 0); cycle();
    drive(1, 16'h0608, 128'hF8, 32'h608, 0); cycle();
    cycle();
    check("t6_pc", {96'd0, out_pc}, {96'd0, 32'h600});
    check("t6_occ", {126'd0, occupancy}, 128'd2);
    check("t6_ready", {127'd0, in_ready}, 128'd0);
    check("t6_valid", {127'd0, out_valid}, 128'd1);
    stall = 1'b0;
    drive(0, 16'h0, 128'h0, 32'h0, 0); cycle();
    check("t6_second", {96'd0, out_pc}, {96'd0, 32'h604});
    cycle();
    check("t6_empty", {126'd0, occupancy}, 128'd0);
    cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
